// File: rtl/stopwatch_watch_control_unit.sv
// Control unit for the stopwatch/watch pair: detects button presses, routes them
// to the unit picked by sw[1], and runs the stopwatch and watch-set FSMs.
module stopwatch_watch_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sw,
    input  logic       btn_r,
    input  logic       btn_l,
    input  logic       sw_zero,
    output logic       sw_run,
    output logic       sw_clear,
    output logic       sw_down,
    output logic       w_run,
    output logic       w_down,
    output logic [1:0] w_set_field,
    output logic       w_adj,
    output logic       disp_sel,
    output logic       disp_hm
);

    typedef enum logic [1:0] {
        SW_STOP  = 2'd0,
        SW_RUN   = 2'd1,
        SW_CLEAR = 2'd2
    } sw_state_e;

    typedef enum logic [1:0] {
        W_NORMAL   = 2'd0,
        W_SET_HOUR = 2'd1,
        W_SET_MIN  = 2'd2,
        W_SET_SEC  = 2'd3
    } w_state_e;

    sw_state_e  sw_state_q;
    w_state_e   w_state_q;
    logic       btn_r_prev_q, btn_l_prev_q;
    logic       sw_run_q, sw_clear_q, sw_down_q;
    logic       w_run_q, w_down_q, w_adj_q;
    logic [1:0] w_set_field_q;
    logic       disp_sel_q, disp_hm_q;

    logic press_r, press_l;
    logic sw_sel;
    logic sw_press_r, sw_press_l, w_press_r, w_press_l;
    logic at_floor;

    assign press_r    = btn_r & ~btn_r_prev_q;
    assign press_l    = btn_l & ~btn_l_prev_q;
    assign sw_sel     = sw[1];
    assign sw_press_r = press_r & sw_sel;
    assign sw_press_l = press_l & sw_sel;
    assign w_press_r  = press_r & ~sw_sel;
    assign w_press_l  = press_l & ~sw_sel;
    // Counting down with nothing left: refuse to start and stop if running.
    assign at_floor   = sw_down_q & sw_zero;

    // Prev registers track the live level during reset so a held button is not a press.
    always_ff @(posedge clk) begin
        btn_r_prev_q <= btn_r;
        btn_l_prev_q <= btn_l;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_sel_q <= 1'b0;
            disp_hm_q  <= 1'b0;
            sw_down_q  <= 1'b0;
            w_down_q   <= 1'b0;
        end else begin
            disp_sel_q <= sw[1];
            disp_hm_q  <= sw[2];
            sw_down_q  <= sw[0];
            w_down_q   <= sw[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_state_q <= SW_STOP;
            sw_run_q   <= 1'b0;
            sw_clear_q <= 1'b0;
        end else begin
            sw_run_q   <= 1'b0;
            sw_clear_q <= 1'b0;
            case (sw_state_q)
                SW_STOP: begin
                    if (sw_press_l) begin
                        sw_state_q <= SW_CLEAR;
                        sw_clear_q <= 1'b1;
                    end else if (sw_press_r && !at_floor) begin
                        sw_state_q <= SW_RUN;
                        sw_run_q   <= 1'b1;
                    end
                end
                SW_RUN: begin
                    if (sw_press_r || at_floor) begin
                        sw_state_q <= SW_STOP;
                    end else begin
                        sw_run_q <= 1'b1;
                    end
                end
                default: sw_state_q <= SW_STOP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q     <= W_NORMAL;
            w_run_q       <= 1'b1;
            w_set_field_q <= 2'd0;
            w_adj_q       <= 1'b0;
        end else begin
            w_adj_q <= 1'b0;
            if (sw_sel) begin
                // Selecting the stopwatch abandons any field being set.
                w_state_q     <= W_NORMAL;
                w_run_q       <= 1'b1;
                w_set_field_q <= 2'd0;
            end else if (w_press_l) begin
                w_state_q     <= w_state_e'(w_state_q + 2'd1);
                w_run_q       <= (w_state_q == W_SET_SEC);
                w_set_field_q <= w_state_q + 2'd1;
            end else if (w_press_r && w_state_q != W_NORMAL) begin
                w_adj_q <= 1'b1;
            end
        end
    end

    assign sw_run      = sw_run_q;
    assign sw_clear    = sw_clear_q;
    assign sw_down     = sw_down_q;
    assign w_run       = w_run_q;
    assign w_down      = w_down_q;
    assign w_set_field = w_set_field_q;
    assign w_adj       = w_adj_q;
    assign disp_sel    = disp_sel_q;
    assign disp_hm     = disp_hm_q;

endmodule

// File: tb/tb_stopwatch_watch_control_unit.sv
// Directed bench for stopwatch_watch_control_unit with hand-computed expectations.
module tb_stopwatch_watch_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] sw;
    logic       btn_r, btn_l, sw_zero;
    logic       sw_run, sw_clear, sw_down, w_run, w_down, w_adj, disp_sel, disp_hm;
    logic [1:0] w_set_field;

    int ntests = 0;
    int nfail  = 0;

    stopwatch_watch_control_unit dut (
        .clk(clk), .reset(reset), .sw(sw), .btn_r(btn_r), .btn_l(btn_l),
        .sw_zero(sw_zero), .sw_run(sw_run), .sw_clear(sw_clear), .sw_down(sw_down),
        .w_run(w_run), .w_down(w_down), .w_set_field(w_set_field), .w_adj(w_adj),
        .disp_sel(disp_sel), .disp_hm(disp_hm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        ntests++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " sw_run"}, sw_run, 0);
        chk({tag, " sw_clear"}, sw_clear, 0);
        chk({tag, " sw_down"}, sw_down, 0);
        chk({tag, " w_run"}, w_run, 1);
        chk({tag, " w_down"}, w_down, 0);
        chk({tag, " w_set_field"}, w_set_field, 0);
        chk({tag, " w_adj"}, w_adj, 0);
        chk({tag, " disp_sel"}, disp_sel, 0);
        chk({tag, " disp_hm"}, disp_hm, 0);
    endtask

    task automatic press_l();
        btn_l = 1'b1; tick();
    endtask

    initial begin
        int pulses;
        reset = 1'b1; sw = 3'b010; btn_r = 1'b1; btn_l = 1'b0; sw_zero = 1'b0;
        tick(); tick();
        chk_reset_vals("rst");

        // 1: button held through reset is not a press
        reset = 1'b0; tick();
        chk("held_no_run", sw_run, 0);
        chk("disp_sel_follow", disp_sel, 1);
        tick();
        chk("held_no_run2", sw_run, 0);
        btn_r = 1'b0; tick();
        btn_r = 1'b1; tick();
        chk("repress_run", sw_run, 1);
        btn_r = 1'b0; tick();

        // 2: run/stop/clear
        btn_l = 1'b1; tick();
        chk("l_in_run_run", sw_run, 1);
        chk("l_in_run_clr", sw_clear, 0);
        btn_l = 1'b0; tick();
        btn_r = 1'b1; tick();
        chk("stop", sw_run, 0);
        btn_r = 1'b0; tick();
        btn_l = 1'b1; tick();
        chk("clear_pulse", sw_clear, 1);
        tick();
        chk("clear_one_cycle", sw_clear, 0);
        chk("clear_no_run", sw_run, 0);
        btn_l = 1'b0; tick();

        // 3: down-count auto-stop
        sw = 3'b011; tick();
        chk("sw_down", sw_down, 1);
        chk("w_down", w_down, 1);
        btn_r = 1'b1; tick();
        chk("down_run", sw_run, 1);
        btn_r = 1'b0; sw_zero = 1'b1; tick();
        chk("auto_stop", sw_run, 0);
        btn_r = 1'b1; tick();
        chk("refuse_start", sw_run, 0);
        btn_r = 1'b0; sw_zero = 1'b0; tick();

        // 4: watch set sequence; stopwatch restarted to show it keeps running unselected
        sw = 3'b110; btn_r = 1'b1; tick();
        chk("disp_hm", disp_hm, 1);
        chk("run_before_switch", sw_run, 1);
        btn_r = 1'b0; sw = 3'b000; tick();
        btn_r = 1'b1; tick();
        chk("normal_r_no_adj", w_adj, 0);
        chk("unsel_keeps_run", sw_run, 1);
        btn_r = 1'b0; tick();
        for (int i = 0; i < 4; i++) begin
            press_l();
            chk($sformatf("field_%0d", i), w_set_field, (i + 1) % 4);
            chk($sformatf("wrun_%0d", i), w_run, (i == 3) ? 1 : 0);
            btn_l = 1'b0; tick();
        end
        press_l(); btn_l = 1'b0; tick();
        press_l(); btn_l = 1'b0; tick();
        chk("at_set_min", w_set_field, 2);
        for (int i = 0; i < 2; i++) begin
            btn_r = 1'b1; tick();
            chk($sformatf("adj_%0d", i), w_adj, 1);
            btn_r = 1'b0; tick();
            chk($sformatf("adj_end_%0d", i), w_adj, 0);
        end
        pulses = 0;
        btn_r = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (w_adj) pulses++;
        end
        chk("hold_one_adj", pulses, 1);
        btn_r = 1'b0; tick();
        btn_r = 1'b1; btn_l = 1'b1; tick();
        chk("simul_set_field", w_set_field, 3);
        chk("simul_set_no_adj", w_adj, 0);
        btn_r = 1'b0; btn_l = 1'b0; tick();

        // 5: abort set when stopwatch selected
        press_l(); btn_l = 1'b0; tick();
        press_l(); btn_l = 1'b0; tick();
        chk("at_set_hour", w_set_field, 1);
        sw = 3'b010; tick();
        chk("abort_field", w_set_field, 0);
        chk("abort_wrun", w_run, 1);
        btn_r = 1'b1; tick();
        chk("stop_sw", sw_run, 0);
        btn_r = 1'b0; tick();
        press_l();
        chk("routed_clear", sw_clear, 1);
        chk("routed_field", w_set_field, 0);
        btn_l = 1'b0; tick();

        // 6: simultaneous in STOP, then reset mid-run
        btn_r = 1'b1; btn_l = 1'b1; tick();
        chk("simul_clear", sw_clear, 1);
        chk("simul_norun", sw_run, 0);
        tick();
        chk("simul_after_run", sw_run, 0);
        btn_r = 1'b0; btn_l = 1'b0; tick();
        btn_r = 1'b1; tick();
        chk("run_pre_reset", sw_run, 1);
        btn_r = 1'b0; sw = 3'b111; reset = 1'b1; tick();
        chk_reset_vals("midrst");
        reset = 1'b0; tick();
        chk("post_rst_run", sw_run, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
